// File: rtl/game_state_ctrl.sv
// ---------------------------------------------------------------------------
// game_state_ctrl
//
// Purpose:
//   This block reads the tube-position/score bus and the bird's y position.
//   It flags bird-vs-tube and bird-vs-floor/ceiling collisions and runs the
//   READY -> PLAY -> OVER game FSM. It drives game_end back to the tube
//   generator and issues a one-cycle clr_req to start a fresh round.
//
// Optional feature:
//   BEST_SCORE_EN - when defined, best_score keeps the highest score seen.
//                   It is captured on each PLAY->OVER edge and cleared only
//                   by clr_n. When undefined, best_score is tied to zero.
//
// Ports:
//   clk10         in   game tick clock
//   clr_n         in   async active-low reset
//   flap          in   player button (level, asynchronous to clk10)
//   bird_y        in   bird top row
//   tubeN_x_pos   in   tube N right edge (exclusive), N = 1..3
//   tubeN_y_pos   in   tube N gap centre, N = 1..3
//   score         in   current round score
//   game_end      out  1 while tubes are frozen (READY/OVER)
//   clr_req       out  one-cycle restart pulse for tube generator/score
//   collide       out  registered collision flag, any source
//   state         out  00 READY, 01 PLAY, 10 OVER
//   best_score    out  highest score reached (BEST_SCORE_EN only)
// ---------------------------------------------------------------------------
module game_state_ctrl #(
  parameter int unsigned BIRD_X    = 200,
  parameter int unsigned BIRD_W    = 20,
  parameter int unsigned BIRD_H    = 16,
  parameter int unsigned TUBE_W    = 60,
  parameter int unsigned GAP_H     = 100,
  parameter int unsigned CEIL_Y    = 0,
  parameter int unsigned FLOOR_Y   = 460,
  parameter int unsigned OVER_HOLD = 20
) (
  input  logic       clk10,
  input  logic       clr_n,
  input  logic       flap,
  input  logic [9:0] bird_y,
  input  logic [9:0] tube1_x_pos,
  input  logic [9:0] tube2_x_pos,
  input  logic [9:0] tube3_x_pos,
  input  logic [9:0] tube1_y_pos,
  input  logic [9:0] tube2_y_pos,
  input  logic [9:0] tube3_y_pos,
  input  logic [7:0] score,
  output logic       game_end,
  output logic       clr_req,
  output logic       collide,
  output logic [1:0] state,
  output logic [7:0] best_score
);

  typedef enum logic [1:0] {
    ST_READY = 2'b00,
    ST_PLAY  = 2'b01,
    ST_OVER  = 2'b10
  } state_t;

  // All collision arithmetic is done in 11 bits so that sums of 10-bit
  // positions and sprite sizes never wrap.
  localparam logic [10:0] BIRD_X_C  = 11'(BIRD_X);
  localparam logic [10:0] H_SPAN_C  = 11'(BIRD_X + BIRD_W + TUBE_W);
  localparam logic [10:0] BIRD_H_C  = 11'(BIRD_H);
  localparam logic [10:0] HALF_GAP  = 11'(GAP_H / 2);
  localparam logic [10:0] CEIL_C    = 11'(CEIL_Y);
  localparam logic [10:0] FLOOR_C   = 11'(FLOOR_Y);

  localparam int HOLD_W = (OVER_HOLD < 1) ? 1 : $clog2(OVER_HOLD + 1);
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(OVER_HOLD);

  state_t            state_q, state_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic              collide_q, collide_d;
  logic              flap_s1_q, flap_s2_q, flap_prev_q;
  logic              flap_rise;
  logic              load_best;

  // The bird overlaps a tube horizontally while the tube's right edge lies
  // strictly inside (BIRD_X, BIRD_X+BIRD_W+TUBE_W). Outside the gap rows it
  // is a hit.
  function automatic logic tube_hit(input logic [9:0] tx, input logic [9:0] ty,
                                    input logic [9:0] by);
    logic [10:0] x11;
    logic [10:0] ty11;
    logic [10:0] by11;
    logic        h_hit;
    logic        v_hit;
    x11   = {1'b0, tx};
    ty11  = {1'b0, ty};
    by11  = {1'b0, by};
    h_hit = (BIRD_X_C < x11) && (x11 < H_SPAN_C);
    v_hit = ((by11 + HALF_GAP) < ty11) || ((by11 + BIRD_H_C) > (ty11 + HALF_GAP));
    return h_hit && v_hit;
  endfunction

  always_comb begin
    logic [10:0] by11;
    logic        bound_hit;
    by11      = {1'b0, bird_y};
    bound_hit = (by11 <= CEIL_C) || ((by11 + BIRD_H_C) > FLOOR_C);
    collide_d = bound_hit
              || tube_hit(tube1_x_pos, tube1_y_pos, bird_y)
              || tube_hit(tube2_x_pos, tube2_y_pos, bird_y)
              || tube_hit(tube3_x_pos, tube3_y_pos, bird_y);
  end

  assign flap_rise = flap_s2_q & ~flap_prev_q;

  // Next-state logic. In PLAY the collision check comes first and flap is
  // never consulted, so a collision always wins over a simultaneous flap.
  // clr_req is decoded from the OVER exit itself, which keeps it out of
  // READY/PLAY and guarantees game_end was already high.
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    game_end   = 1'b1;
    clr_req    = 1'b0;
    load_best  = 1'b0;
    case (state_q)
      ST_READY: begin
        if (flap_rise) state_d = ST_PLAY;
      end
      ST_PLAY: begin
        game_end = 1'b0;
        if (collide_q) begin
          state_d    = ST_OVER;
          hold_cnt_d = HOLD_LOAD;
          load_best  = 1'b1;
        end
      end
      ST_OVER: begin
        if (hold_cnt_q != '0) begin
          hold_cnt_d = hold_cnt_q - HOLD_W'(1);
        end else if (flap_rise) begin
          state_d = ST_READY;
          clr_req = 1'b1;
        end
      end
      default: begin
        state_d = ST_READY;
      end
    endcase
  end

  always_ff @(posedge clk10 or negedge clr_n) begin
    if (!clr_n) begin
      state_q     <= ST_READY;
      hold_cnt_q  <= '0;
      collide_q   <= 1'b0;
      flap_s1_q   <= 1'b0;
      flap_s2_q   <= 1'b0;
      flap_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_cnt_q  <= hold_cnt_d;
      collide_q   <= collide_d;
      flap_s1_q   <= flap;
      flap_s2_q   <= flap_s1_q;
      flap_prev_q <= flap_s2_q;
    end
  end

  assign collide = collide_q;
  assign state   = state_q;

`ifdef BEST_SCORE_EN
  logic [7:0] best_score_q, best_score_d;

  // Ties keep the old value; clr_req does not touch this register.
  always_comb begin
    best_score_d = best_score_q;
    if (load_best && (score > best_score_q)) best_score_d = score;
  end

  always_ff @(posedge clk10 or negedge clr_n) begin
    if (!clr_n) best_score_q <= 8'd0;
    else        best_score_q <= best_score_d;
  end

  assign best_score = best_score_q;
`else
  logic unused_best;
  assign unused_best = ^{score, load_best};
  assign best_score  = 8'd0;
`endif

endmodule

// File: tb/tb_game_state_ctrl.sv
// ---------------------------------------------------------------------------
// tb_game_state_ctrl
//
// Purpose:
//   Self-checking bench for game_state_ctrl. A driver applies inputs just
//   after each rising clock edge and advances a reference model of the game
//   rules. It then pushes the expected outputs into a scoreboard queue. A
//   monitor pops one entry on every falling edge and compares it with the
//   DUT outputs. The expected best_score follows BEST_SCORE_EN.
// ---------------------------------------------------------------------------
module tb_game_state_ctrl;

  localparam int BIRD_X    = 200;
  localparam int BIRD_W    = 20;
  localparam int BIRD_H    = 16;
  localparam int TUBE_W    = 60;
  localparam int GAP_H     = 100;
  localparam int CEIL_Y    = 0;
  localparam int FLOOR_Y   = 460;
  localparam int OVER_HOLD = 20;

  logic       clk10;
  logic       clr_n;
  logic       flap;
  logic [9:0] bird_y;
  logic [9:0] t1x, t2x, t3x, t1y, t2y, t3y;
  logic [7:0] score;
  logic       game_end, clr_req, collide;
  logic [1:0] state;
  logic [7:0] best_score;

  game_state_ctrl dut (
    .clk10       (clk10),
    .clr_n       (clr_n),
    .flap        (flap),
    .bird_y      (bird_y),
    .tube1_x_pos (t1x),
    .tube2_x_pos (t2x),
    .tube3_x_pos (t3x),
    .tube1_y_pos (t1y),
    .tube2_y_pos (t2y),
    .tube3_y_pos (t3y),
    .score       (score),
    .game_end    (game_end),
    .clr_req     (clr_req),
    .collide     (collide),
    .state       (state),
    .best_score  (best_score)
  );

  initial clk10 = 1'b0;
  always #5 clk10 = ~clk10;

  // Values to be applied after the next rising edge.
  logic       nx_clr_n, nx_flap;
  logic [9:0] nx_by, nx_t1x, nx_t2x, nx_t3x, nx_t1y, nx_t2y, nx_t3y;
  logic [7:0] nx_score;

  typedef struct {
    int st;
    bit ge;
    bit cr;
    bit col;
    int best;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   drv_done = 0;

  // Reference model: phase 0/1/2 = READY/PLAY/OVER. The flap history holds
  // the values sampled at the most recent clock edges, newest first.
  int m_phase;
  int m_hold;
  int m_best;
  bit m_collide;
  bit m_fh[$];

  function automatic bit hits_tube(int by, int tx, int ty);
    bit h, v;
    h = (BIRD_X < tx) && (tx < BIRD_X + BIRD_W + TUBE_W);
    v = (by + GAP_H / 2 < ty) || (by + BIRD_H > ty + GAP_H / 2);
    return h && v;
  endfunction

  function automatic bit any_hit();
    int by;
    by = int'(bird_y);
    return (by <= CEIL_Y) || (by + BIRD_H > FLOOR_Y)
        || hits_tube(by, int'(t1x), int'(t1y))
        || hits_tube(by, int'(t2x), int'(t2y))
        || hits_tube(by, int'(t3x), int'(t3y));
  endfunction

  function automatic void model_reset();
    m_phase   = 0;
    m_hold    = 0;
    m_best    = 0;
    m_collide = 0;
    m_fh      = '{0, 0, 0};
  endfunction

  // A press becomes a rise two edges after it is first sampled. That is the
  // sample two edges back being high while the one before it was low.
  function automatic void model_edge();
    bit rise;
    if (!clr_n) return;
    rise = m_fh[1] && !m_fh[2];
    case (m_phase)
      0: if (rise) m_phase = 1;
      1: if (m_collide) begin
           m_phase = 2;
           m_hold  = OVER_HOLD;
`ifdef BEST_SCORE_EN
           if (int'(score) > m_best) m_best = int'(score);
`endif
         end
      default: begin
        if (m_hold > 0) m_hold = m_hold - 1;
        else if (rise) m_phase = 0;
      end
    endcase
    m_collide = any_hit();
    m_fh.push_front(flap);
    void'(m_fh.pop_back());
  endfunction

  function automatic exp_t model_outputs();
    exp_t e;
    e.st   = m_phase;
    e.ge   = (m_phase != 1);
    e.cr   = (m_phase == 2) && (m_hold == 0) && m_fh[1] && !m_fh[2];
    e.col  = m_collide;
    e.best = m_best;
    return e;
  endfunction

  task automatic apply_stimulus(input int n);
    repeat (n) begin
      @(posedge clk10);
      model_edge();
      #1;
      clr_n  = nx_clr_n;
      flap   = nx_flap;
      bird_y = nx_by;
      t1x = nx_t1x; t2x = nx_t2x; t3x = nx_t3x;
      t1y = nx_t1y; t2y = nx_t2y; t3y = nx_t3y;
      score  = nx_score;
      if (!clr_n) model_reset();
      sb_q.push_back(model_outputs());
    end
  endtask

  task automatic set_safe();
    nx_flap = 0;
    nx_by   = 10'd200;
    nx_t1x  = 10'd600; nx_t2x = 10'd600; nx_t3x = 10'd600;
    nx_t1y  = 10'd240; nx_t2y = 10'd240; nx_t3y = 10'd240;
  endtask

  task automatic randomize_inputs();
    nx_flap  = ($urandom_range(0, 3) == 0);
    nx_t1x   = 10'($urandom_range(150, 330));
    nx_t2x   = 10'($urandom_range(0, 639));
    nx_t3x   = 10'($urandom_range(0, 639));
    nx_t1y   = 10'($urandom_range(80, 400));
    nx_t2y   = 10'($urandom_range(80, 400));
    nx_t3y   = 10'($urandom_range(80, 400));
    nx_score = 8'($urandom_range(0, 255));
    if ($urandom_range(0, 1) == 0) nx_by = nx_t1y - 10'd20;
    else                           nx_by = 10'($urandom_range(0, 479));
  endtask

  // One flap press for a single cycle, then released.
  task automatic pulse_flap(input int gap);
    nx_flap = 1;
    apply_stimulus(1);
    nx_flap = 0;
    apply_stimulus(gap);
  endtask

  task automatic check_output(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Monitor: every cycle is an output cycle, so one entry is consumed per
  // falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk10);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check_output("state",      int'(state),      e.st);
        check_output("game_end",   int'(game_end),   int'(e.ge));
        check_output("clr_req",    int'(clr_req),    int'(e.cr));
        check_output("collide",    int'(collide),    int'(e.col));
        check_output("best_score", int'(best_score), e.best);
      end
      if (drv_done && sb_q.size() == 0) break;
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: bench did not complete (checks=%0d)", n_checks);
    $fatal(1, "[TB] timeout");
  end

  // Driver
  initial begin
    model_reset();
    clr_n = 0; flap = 0; bird_y = 10'd200; score = 8'd0;
    t1x = 10'd600; t2x = 10'd600; t3x = 10'd600;
    t1y = 10'd240; t2y = 10'd240; t3y = 10'd240;
    nx_score = 8'd0;

    // Reset held with random inputs.
    $display("[TB] reset");
    nx_clr_n = 0;
    for (int i = 0; i < 3; i++) begin
      randomize_inputs();
      apply_stimulus(1);
    end
    nx_clr_n = 1;
    set_safe();
    nx_score = 8'd0;
    apply_stimulus(3);

    // Start: flap held high.
    $display("[TB] start");
    nx_flap = 1;
    apply_stimulus(5);
    nx_flap = 0;
    apply_stimulus(3);

    // Tube hit above the gap.
    $display("[TB] tube hit");
    nx_by = 10'd100; nx_t1x = 10'd230; nx_t1y = 10'd240;
    apply_stimulus(4);
    set_safe();
    apply_stimulus(OVER_HOLD + 3);
    pulse_flap(4);

    // Gap pass, then the horizontal boundary tube_x == BIRD_X.
    $display("[TB] gap pass");
    pulse_flap(4);
    nx_by = 10'd200; nx_t1x = 10'd230; nx_t1y = 10'd240;
    apply_stimulus(5);
    nx_by = 10'd100; nx_t1x = 10'd200;
    apply_stimulus(4);

    // Floor hit coinciding with a flap rise; flap pulses during the hold.
    $display("[TB] floor and restart");
    nx_score = 8'd7;
    set_safe();
    nx_flap = 1;
    apply_stimulus(1);
    nx_by = 10'd445;
    apply_stimulus(1);
    nx_flap = 0;
    apply_stimulus(3);
    set_safe();
    for (int i = 0; i < 7; i++) pulse_flap(2);
    apply_stimulus(4);
    pulse_flap(4);

    // Second round dies at a lower score; best must not drop.
    $display("[TB] second round");
    nx_score = 8'd5;
    pulse_flap(4);
    nx_by = 10'd0;
    apply_stimulus(3);
    set_safe();
    apply_stimulus(OVER_HOLD + 2);
    pulse_flap(4);

    // Randomized play with occasional mid-round resets.
    $display("[TB] random");
    for (int i = 0; i < 2500; i++) begin
      randomize_inputs();
      nx_clr_n = ($urandom_range(0, 299) != 0);
      apply_stimulus(1);
    end
    nx_clr_n = 1;
    set_safe();
    apply_stimulus(2);
    drv_done = 1;
  end

endmodule
